// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner with frame-synchronous double buffering.
// Define SEVSEG_LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    load,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    r_s1, r_s2, r_s3;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val, r_disp_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic                    r_pend_valid;
    logic                    r_blank;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick, w_wrap, w_commit, w_upd, w_hide;
    logic [IDX_W-1:0]        w_idx_next, w_sel;
    logic [4*NUM_DIGITS-1:0] w_disp_val_next;
    logic [NUM_DIGITS-1:0]   w_disp_dp_next;
    logic [3:0]              w_nib;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick     = r_s2 & ~r_s3;
    assign w_wrap     = w_tick & (r_idx == LAST_IDX);
    assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_commit   = w_wrap & r_pend_valid;
    assign w_sel      = w_tick ? w_idx_next : r_idx;
    assign w_upd      = w_tick | (blank ^ r_blank);

    // Decode from the post-commit buffer so digit 0 of a new frame already shows new data.
    assign w_disp_val_next = w_commit ? r_pend_val : r_disp_val;
    assign w_disp_dp_next  = w_commit ? r_pend_dp  : r_disp_dp;
    assign w_nib           = 4'(w_disp_val_next >> (4 * w_sel));

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    // NOTE: default assigned first so the combinational block never infers a latch.
    always_comb begin
        w_hide = 1'b0;
        if (w_sel != '0 && !w_disp_dp_next[w_sel])
            w_hide = ((w_disp_val_next >> (4 * w_sel)) == '0);
    end
`else
    assign w_hide = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_idx        <= LAST_IDX;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_blank      <= 1'b0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && (w_idx_next == '0);
            r_blank      <= blank;
            if (w_tick)
                r_idx <= w_idx_next;
            if (w_commit) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            // A load coinciding with a commit keeps the new data pending.
            if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_mask;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
            if (w_upd) begin
                r_seg <= hex_glyph(w_nib);
                r_dp  <= ~w_disp_dp_next[w_sel];
                r_an  <= (blank || w_hide) ? '1 : ~(NUM_DIGITS'(1) << w_sel);
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed seven-segment display driver for the calculator's display board; sits directly downstream of the clock divider. Samples the divider's slow square wave as a scan-rate enable, without using it as a clock, and steps one active-low anode per rising edge. Outputs the hex glyph and decimal point for the selected digit. Display values are double-buffered and committed only at frame boundaries, so a digit never shows a torn value.

## Interface
- NUM_DIGITS, 8, number of digits scanned; legal range 2..8.
- clk_in  input  1  system clock; everything is synchronous to it.
- reset  input  1  asynchronous, active-low; 0 resets the block.
- scan_clk  input  1  divider output; asynchronous level, synchronized internally.
- value  input  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i], digit 0 is rightmost.
- dp_mask  input  NUM_DIGITS  1 lights the decimal point of digit i; captured with value.
- load  input  1  one-cycle strobe that captures value and dp_mask into the pending buffer.
- blank  input  1  1 forces all anodes off; scanning continues.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point cathode, active-low.
- an  output  NUM_DIGITS  anodes, active-low, at most one low.
- frame_done  output  1  one-cycle pulse when digit 0 is driven.

## Operation
- **Synchronizer:** scan_clk passes through 2 flops (s1, s2) plus a history flop s3. tick = s2 & ~s3.
- **Digit index:** register idx, reset value NUM_DIGITS-1. Each tick: idx wraps NUM_DIGITS-1 -> 0, otherwise idx + 1.
- **Buffering:**
  - load writes pend_val, pend_dp and sets pend_valid.
  - On a wrapping tick with pend_valid=1, disp_val/disp_dp take the pend contents and pend_valid clears.
  - A load in the same cycle as a commit: the old pending contents commit, the new data becomes pending, and pend_valid stays 1.
  - Repeated loads before a commit overwrite; the last one wins.
- **Decode (registered, from next idx):**
  - Standard hex glyphs. Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
  - dp = ~disp_dp[idx].
  - an = ~(1 << idx), unless blank=1 or the digit is suppressed; then an is all ones.
- **Outputs:** seg/dp/an update only on tick cycles or on blank changes. blank takes effect on the next clk_in edge.
- **Reset (async, any time):**
  - idx = NUM_DIGITS-1; disp/pend registers 0; pend_valid 0.
  - an all ones, seg 7'h7F, dp 1, frame_done 0.
  - s1..s3 are cleared to 0, so scan_clk held high through reset release yields one tick.

## Timing
- Let E0 be the first clk_in edge sampling scan_clk=1. s2=1 after E1; idx, outputs and frame_done update at E2. Latency from E0 is 2 edges.
- One tick per scan_clk rising edge, provided scan_clk stays high and low for at least 2 clk_in cycles each.
- A load at edge L is visible no earlier than the next wrapping tick after L. The worst case is one full frame (NUM_DIGITS ticks) plus 2 cycles.
- frame_done is high exactly one cycle, coincident with the output update that selects digit 0.
- The first tick after reset selects digit 0 and pulses frame_done.

## Configuration
- Macro SEVSEG_LEADING_ZERO_BLANK_EN.
- **Defined:** digits above the most significant nonzero nibble of disp_val have their anode held high. Digit 0 is always shown. A digit with its disp_dp bit set is never suppressed. Value 0 shows only a single "0".
- **Undefined:** every digit is always driven, including leading zeros. The suppression logic is absent.

## Test plan
- **Reset:** hold reset=0 with scan_clk toggling -> an=8'hFF, seg=7'h7F, dp=1, frame_done=0. Release, then first scan_clk rise -> an=8'hFE exactly 2 edges after E0, frame_done pulses once.
- **Glyph sweep:** load value=32'h76543210, dp_mask=8'h04, then run 2 frames -> second frame shows digits 0..7 with seg 7'h40, 7'h79, ..., and dp=0 only while an=8'hFB.
- **Frame boundary:** load 32'h11111111 mid-frame, then load 32'h22222222 before the wrap -> no digit of the current frame changes, and the next frame is all "2" (7'h24).
- **Load coincident with commit:** pending 32'hAAAAAAAA, then load 32'hBBBBBBBB in the wrap cycle -> this frame shows A (7'h08), the following frame shows B (7'h03).
- **Blank / mid-scan reset:** blank=1 for 3 ticks -> an=8'hFF while idx keeps advancing, and an resumes at the correct digit. Async reset mid-frame -> outputs return to reset values without waiting for a clk_in edge.
- **Leading-zero blanking (macro defined):** value 32'h00000120 -> only digits 0..2 are lit. value 0 -> only digit 0 is lit, showing 7'h40.
